seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receive-side counterpart of the alarm clock's multiplexed 4-digit seven-segment output.
- Samples the scanned segment and anode lines, rejects transition glitches, and decodes each segment pattern back to BCD.
- Assembles the four digits into a 16-bit frame and flags when a complete frame is ready.
- Used as a display readback/self-check block beside the alarm clock and as the display monitor in benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (min 1).
- TIMEOUT_CYCLES, 1000000, maximum cycles between accepted digits while a frame is incomplete (10 ms at 100 MHz).

Ports:
- i_Clk_100MHz  input  1  system clock.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Segments  input  7  segment lines {g,f,e,d,c,b,a}, active-low.
- i_Anodes  input  4  digit enables, active-low; bit 0 = rightmost digit (minutes ones).
- o_Digits  output  16  last complete frame {d3,d2,d1,d0}, 4 bits per digit.
- o_Frame_Valid  output  1  one-cycle pulse when o_Digits updates.
- o_Changed  output  1  one-cycle pulse, coincident with o_Frame_Valid, when the new frame differs from the previous one.
- o_Decode_Error  output  1  held with each frame; 1 if any digit in that frame was an undecodable pattern.
- o_Timeout  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset: asynchronous; clears all state. All outputs are 0, FSM is in IDLE, capture mask = 0.
- Input stage: i_Segments and i_Anodes pass through a 2-flop synchronizer. Total latency from input to acceptance = 2 + STABLE_CYCLES cycles.
- Stability filter:
  - A sample is a candidate only if exactly one anode bit is 0.
  - Counter increments while the synchronized {anodes, segments} are unchanged; it clears on any change, on no anode active, or on more than one anode active.
  - When the counter reaches STABLE_CYCLES, the digit is accepted once.
  - No further acceptance until {anodes, segments} changes.
- Decode (active-low patterns):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - All segments off (1111111) decodes to 4'hA (blank, not an error).
  - Any other pattern decodes to 4'hF and sets that digit's error bit.
- FSM:
  - IDLE: first accepted digit -> COLLECT; store the digit and set its mask bit.
  - COLLECT:
    - Each acceptance stores the digit and sets its mask bit. A repeat acceptance of an already-captured digit overwrites it.
    - Timeout counter reloads on every acceptance.
    - When the mask reaches 4'b1111 -> PUBLISH.
    - If the timeout counter reaches TIMEOUT_CYCLES first: pulse o_Timeout, clear mask and errors -> IDLE. o_Digits is left unchanged.
  - PUBLISH (one cycle):
    - Load o_Digits; set o_Decode_Error = OR of the digit error bits.
    - Pulse o_Frame_Valid; pulse o_Changed if the new value differs from the old o_Digits.
    - Clear mask and errors -> IDLE.
    - An acceptance arriving in the same cycle is stored as the first digit of the next frame, and the FSM goes to COLLECT instead of IDLE.
  - The first frame after reset always asserts o_Changed.
- Widths: stability counter is $clog2(STABLE_CYCLES+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. Both saturate and never wrap.

Decomposition:
- Package seven_seg_pkg holds:
  - active-low segment constants for 0–9 and blank;
  - BLANK_CODE = 4'hA and ERR_CODE = 4'hF;
  - the FSM state typedef (IDLE, COLLECT, PUBLISH);
  - a seg_to_bcd decode function.
- One sub-module: seg_stability_filter. It contains the synchronizer and stability counter and outputs an accept strobe, the digit index (0–3) and the raw segments.

Test Plan:
- Scan "1234" (d3..d0 = 1,2,3,4), 20 cycles per digit, ascending anode order -> one o_Frame_Valid, o_Digits=16'h1234, o_Changed=1, o_Decode_Error=0.
- Repeat the identical scan -> o_Frame_Valid=1, o_Changed=0, o_Digits stays 16'h1234.
- Scan with 2-cycle segment glitches at each anode switch (STABLE_CYCLES=4) -> glitch values never captured; o_Digits=16'h1234.
- Drive digit 2 as 0101010 and d3 as blank, others 0,5 -> o_Digits=16'hAF05 (d3=A, d2=F, d1=0, d0=5), o_Decode_Error=1.
- Scan only d0 and d1, then hold anodes at 4'b1111 for TIMEOUT_CYCLES -> o_Timeout pulses once, no o_Frame_Valid; the next full scan of "0712" gives 16'h0712.
- Assert i_Reset mid-frame after two digits -> all outputs 0 immediately; the following full scan yields a single valid frame with o_Changed=1.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module : seven_seg_pkg
// Desc   : Segment constants, FSM states and segment-to-BCD decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_CODE = 4'hA;
    localparam logic [3:0] ERR_CODE   = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    function automatic logic [3:0] seg_to_bcd(input logic [6:0] seg);
        logic [3:0] bcd;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BLANK_CODE;
            default:   bcd = ERR_CODE;
        endcase
        return bcd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_capture_filter.sv
// ============================================================================
// Module : seg_stability_filter
// Desc   : Synchronizes scanned segment/anode lines and strobes once per
//          stable single-digit pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_stability_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_segments,
    input  logic [3:0] i_anodes,
    output logic       o_accept,
    output logic [1:0] o_index,
    output logic [6:0] o_segments
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] c_stable = CW'(STABLE_CYCLES);

    logic [10:0]   r_sync1, r_sync2, r_last;
    logic [CW-1:0] r_cnt;
    logic          r_accept;
    logic [1:0]    r_index;
    logic [6:0]    r_seg;

    logic          w_cand, w_same, w_fire;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_idx;

    assign w_cand = ($countones(~r_sync2[10:7]) == 1);
    assign w_same = (r_sync2 == r_last);

    always_comb begin
        w_cnt_next = '0;
        if (w_cand) begin
            if (!w_same)
                w_cnt_next = CW'(1);
            else if (r_cnt == c_stable)
                w_cnt_next = c_stable;
            else
                w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Fire on reaching the threshold; a changed pattern restarts the count
    // even when the previous one had saturated (matters for STABLE_CYCLES=1).
    assign w_fire = w_cand && (w_cnt_next == c_stable) &&
                    (!w_same || (r_cnt != c_stable));

    always_comb begin
        w_idx = 2'd0;
        case (r_sync2[10:7])
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_last   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
            r_index  <= 2'd0;
            r_seg    <= '0;
        end else begin
            r_sync1  <= {i_anodes, i_segments};
            r_sync2  <= r_sync1;
            r_last   <= r_sync2;
            r_cnt    <= w_cnt_next;
            r_accept <= w_fire;
            r_index  <= w_idx;
            r_seg    <= r_sync2[6:0];
        end
    end

    assign o_accept   = r_accept;
    assign o_index    = r_index;
    assign o_segments = r_seg;

endmodule

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
// Module : seven_seg_capture
// Desc   : Reassembles a scanned 4-digit seven-segment display into BCD frames.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_Clk_100MHz,
    input  logic        i_Reset,
    input  logic [6:0]  i_Segments,
    input  logic [3:0]  i_Anodes,
    output logic [15:0] o_Digits,
    output logic        o_Frame_Valid,
    output logic        o_Changed,
    output logic        o_Decode_Error,
    output logic        o_Timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT_CYCLES);

    logic       w_accept;
    logic [1:0] w_idx;
    logic [6:0] w_seg;
    logic [3:0] w_bcd;
    logic       w_bad;

    seg_stability_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk      (i_Clk_100MHz),
        .i_rst      (i_Reset),
        .i_segments (i_Segments),
        .i_anodes   (i_Anodes),
        .o_accept   (w_accept),
        .o_index    (w_idx),
        .o_segments (w_seg)
    );

    assign w_bcd = seg_to_bcd(w_seg);
    assign w_bad = (w_bcd == ERR_CODE);

    state_t        r_state, w_state;
    logic [3:0]    r_mask, w_mask;
    logic [3:0]    r_err, w_err;
    logic [15:0]   r_buf, w_buf;
    logic [TW-1:0] r_tcnt, w_tcnt;
    logic [15:0]   r_digits, w_digits;
    logic          r_dec_err, w_dec_err;
    logic          r_valid, w_valid;
    logic          r_changed, w_changed;
    logic          r_timeout, w_timeout;
    logic          r_seen, w_seen;

    always_comb begin
        w_state   = r_state;
        w_mask    = r_mask;
        w_err     = r_err;
        w_buf     = r_buf;
        w_tcnt    = r_tcnt;
        w_digits  = r_digits;
        w_dec_err = r_dec_err;
        w_valid   = 1'b0;
        w_changed = 1'b0;
        w_timeout = 1'b0;
        w_seen    = r_seen;
        case (r_state)
            IDLE: begin
                w_tcnt = '0;
                if (w_accept) begin
                    w_mask[w_idx]              = 1'b1;
                    w_err[w_idx]               = w_bad;
                    w_buf[{w_idx, 2'b00} +: 4] = w_bcd;
                    w_state                    = COLLECT;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    w_mask[w_idx]              = 1'b1;
                    w_err[w_idx]               = w_bad;
                    w_buf[{w_idx, 2'b00} +: 4] = w_bcd;
                    w_tcnt                     = '0;
                    if (w_mask == 4'b1111)
                        w_state = PUBLISH;
                end else if (r_tcnt == c_timeout) begin
                    w_timeout = 1'b1;
                    w_mask    = '0;
                    w_err     = '0;
                    w_tcnt    = '0;
                    w_state   = IDLE;
                end else begin
                    w_tcnt = r_tcnt + 1'b1;
                end
            end
            PUBLISH: begin
                w_digits  = r_buf;
                w_dec_err = |r_err;
                w_valid   = 1'b1;
                // r_seen forces o_Changed on the first frame, even if it is 0000
                w_changed = (r_buf != r_digits) || !r_seen;
                w_seen    = 1'b1;
                w_mask    = '0;
                w_err     = '0;
                w_tcnt    = '0;
                w_state   = IDLE;
                if (w_accept) begin
                    w_mask[w_idx]              = 1'b1;
                    w_err[w_idx]               = w_bad;
                    w_buf[{w_idx, 2'b00} +: 4] = w_bcd;
                    w_state                    = COLLECT;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk_100MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_err     <= '0;
            r_buf     <= '0;
            r_tcnt    <= '0;
            r_digits  <= '0;
            r_dec_err <= 1'b0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_timeout <= 1'b0;
            r_seen    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_mask    <= w_mask;
            r_err     <= w_err;
            r_buf     <= w_buf;
            r_tcnt    <= w_tcnt;
            r_digits  <= w_digits;
            r_dec_err <= w_dec_err;
            r_valid   <= w_valid;
            r_changed <= w_changed;
            r_timeout <= w_timeout;
            r_seen    <= w_seen;
        end
    end

    assign o_Digits       = r_digits;
    assign o_Frame_Valid  = r_valid;
    assign o_Changed      = r_changed;
    assign o_Decode_Error = r_dec_err;
    assign o_Timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// ============================================================================
// Module : tb_seven_seg_capture
// Desc   : Scoreboard bench for seven_seg_capture frame reassembly.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  segs = SEG_BLANK;
    logic [3:0]  anodes = 4'b1111;
    logic [15:0] o_Digits;
    logic        o_Frame_Valid, o_Changed, o_Decode_Error, o_Timeout;

    seven_seg_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_Clk_100MHz  (clk),
        .i_Reset       (rst),
        .i_Segments    (segs),
        .i_Anodes      (anodes),
        .o_Digits      (o_Digits),
        .o_Frame_Valid (o_Frame_Valid),
        .o_Changed     (o_Changed),
        .o_Decode_Error(o_Decode_Error),
        .o_Timeout     (o_Timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        ch;
        logic        er;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   n_timeouts = 0;

    // Scoreboard side: every published frame is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (o_Timeout) n_timeouts++;
        if (o_Frame_Valid) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got digits=%h, required no frame", o_Digits);
            end else begin
                e = sb_q.pop_front();
                if (o_Digits !== e.d) begin
                    n_fail++;
                    $display("FAIL frame_digits: got %h, required %h", o_Digits, e.d);
                end
                n_tests++;
                if (o_Changed !== e.ch) begin
                    n_fail++;
                    $display("FAIL frame_changed: got %b, required %b (digits %h)", o_Changed, e.ch, e.d);
                end
                n_tests++;
                if (o_Decode_Error !== e.er) begin
                    n_fail++;
                    $display("FAIL frame_decode_error: got %b, required %b (digits %h)", o_Decode_Error, e.er, e.d);
                end
            end
        end
    end

    task automatic show(input int idx, input logic [6:0] seg, input int cyc);
        logic [3:0] a;
        a      = 4'b0001 << idx;
        anodes = ~a;
        segs   = seg;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic go_dark(input int cyc);
        anodes = 4'b1111;
        segs   = SEG_BLANK;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        show(0, s0, 20);
        show(1, s1, 20);
        show(2, s2, 20);
        show(3, s3, 20);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_no_frame: got %0d frames pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        go_dark(10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_Digits, o_Frame_Valid, o_Changed, o_Decode_Error, o_Timeout} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got digits=%h v=%b c=%b e=%b t=%b, required all 0",
                     o_Digits, o_Frame_Valid, o_Changed, o_Decode_Error, o_Timeout);
        end
        rst = 1'b0;
        go_dark(5);
    endtask

    task automatic test_basic();
        sb_q.push_back('{d: 16'h1234, ch: 1'b1, er: 1'b0});
        scan(SEG_4, SEG_3, SEG_2, SEG_1);
        go_dark(5);
        wait_drain("basic");
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{d: 16'h1234, ch: 1'b0, er: 1'b0});
        scan(SEG_4, SEG_3, SEG_2, SEG_1);
        go_dark(5);
        wait_drain("repeat");
    endtask

    task automatic test_glitch();
        logic [6:0] vals [4];
        vals = '{SEG_4, SEG_3, SEG_2, SEG_1};
        sb_q.push_back('{d: 16'h1234, ch: 1'b0, er: 1'b0});
        for (int i = 0; i < 4; i++) begin
            show(i, SEG_8, 2);
            show(i, vals[i], 18);
        end
        go_dark(5);
        wait_drain("glitch");
        n_tests++;
        if (o_Digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL glitch_hold: got %h, required 1234", o_Digits);
        end
    endtask

    task automatic test_decode_error();
        sb_q.push_back('{d: 16'hAF05, ch: 1'b1, er: 1'b1});
        scan(SEG_5, SEG_0, 7'b0101010, SEG_BLANK);
        go_dark(5);
        wait_drain("decode_err");
    endtask

    task automatic test_reset_mid();
        show(0, SEG_3, 20);
        show(1, SEG_6, 20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({o_Digits, o_Frame_Valid, o_Changed, o_Decode_Error, o_Timeout} !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got digits=%h v=%b c=%b e=%b t=%b, required all 0",
                     o_Digits, o_Frame_Valid, o_Changed, o_Decode_Error, o_Timeout);
        end
        @(negedge clk);
        go_dark(3);
        rst = 1'b0;
        go_dark(5);
        sb_q.push_back('{d: 16'h0000, ch: 1'b1, er: 1'b0});
        scan(SEG_0, SEG_0, SEG_0, SEG_0);
        go_dark(5);
        wait_drain("after_reset");
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_timeouts;
        show(0, SEG_9, 20);
        show(1, SEG_8, 20);
        go_dark(TIMEOUT + 30);
        n_tests++;
        if (n_timeouts - t0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d, required 1", n_timeouts - t0);
        end
        n_tests++;
        if (o_Digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_digits_kept: got %h, required 0000", o_Digits);
        end
        sb_q.push_back('{d: 16'h0712, ch: 1'b1, er: 1'b0});
        scan(SEG_2, SEG_1, SEG_7, SEG_0);
        go_dark(5);
        wait_drain("after_timeout");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_decode_error();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
